acc_unit: RTL and testbench
===========================

Name: acc_unit

Overview:
- Accumulator and status-flag stage placed directly downstream of the n-bit ALU in the accumulator-based processor.
- Accepts one operation at a time through a valid/ready handshake.
- Drives the ALU operand, control and carry-in lines from registers, captures the ALU result into the accumulator, and maintains the C, V, Z and N flags.
- Computes Z and N itself from the captured result. The ALU zero output is not used.

Parameters:
- n, 8, data width; must equal the width of the attached ALU.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept an operation (IDLE only)
- in_op  input  4  operation code, see Behaviour
- in_data  input  n  operand
- alu_in0  output  n  ALU operand 0; always equals acc
- alu_in1  output  n  ALU operand 1; registered operand
- alu_ctrl  output  3  ALU control, registered
- alu_c_in  output  1  ALU carry in, registered
- alu_out  input  n  ALU result
- alu_c_out  input  1  ALU carry out
- alu_v  input  1  ALU overflow
- acc  output  n  accumulator
- flag_c, flag_v, flag_z, flag_n  output  1 each  status flags
- done  output  1  one-cycle pulse: result and flags updated
- err  output  1  one-cycle pulse: illegal opcode retired

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state goes to IDLE.
  - acc, alu_in1, alu_ctrl, alu_c_in, all flags, done and err go to 0.
  - Reset asserted mid-operation abandons the operation; no partial update survives.
- State machine:
  - IDLE -> EXEC on in_valid&&in_ready. That edge loads the op register, loads alu_in1<=in_data, and sets alu_ctrl/alu_c_in per the opcode table.
  - EXEC -> RESP unconditionally. That edge writes acc and the flags.
  - RESP -> IDLE unconditionally. done (or err) is high for exactly the RESP cycle.
- in_ready=1 only in IDLE. in_valid outside IDLE is ignored; the requester must hold its request.
- Latency: accept at edge E0, result visible on acc after E1, done high between E1 and E2. Max throughput is 1 op per 3 cycles. Every opcode, including LDA, CLR and illegal, takes the same path.
- Opcode table (in_op -> alu_ctrl, alu_c_in, effect):
  - 0 ADD -> 000, 0
  - 1 SUB -> 001, 1
  - 2 OR -> 010, 0
  - 3 ORN -> 011, 0
  - 4 AND -> 100, 0
  - 5 ANDN -> 101, 0
  - 6 NOTA -> 110, 0
  - 7 NOTB -> 111, 0
  - 8 ADC -> 000, flag_c sampled at accept
  - 9 SBC -> 001, flag_c sampled at accept
  - 10 LDA -> acc<=alu_in1
  - 11 CLR -> acc<=0 and all flags <=0
  - 12-15 illegal -> acc and flags unchanged; err pulses instead of done
- Flag rules at the EXEC edge:
  - ADD/SUB/ADC/SBC: C<=alu_c_out, V<=alu_v.
  - Logic/complement ops (2-7) and LDA: C and V unchanged.
  - All ops except CLR and illegal: Z<=(new acc==0), N<=new acc[n-1].
- Arithmetic:
  - Results are modulo 2^n; carry beyond bit n-1 appears only in C.
  - ADC/SBC chain multi-word values: the low word uses ADD/SUB, higher words use ADC/SBC.
- alu_in0 is combinationally acc. The ALU outputs are sampled only at the EXEC edge, giving one full cycle of settle time.

Test Plan:
- Reset mid-EXEC: assert rst_n=0 during EXEC -> acc=0, flags=0, in_ready=1 after release, no done pulse.
- Add with carry and overflow: n=8, LDA 0x7F then ADD 0x01 -> acc=0x80, V=1, C=0, N=1, Z=0, done one cycle.
- Subtract to zero, then borrow: LDA 0x05, SUB 0x05 -> acc=0x00, Z=1, C=1 (no borrow). Then SUB 0x01 -> acc=0xFF, C=0, N=1.
- Multi-word add: 16-bit 0x01FF+0x0001 as ADD 0xFF+0x01 (acc=0x00, C=1) then LDA 0x01, ADC 0x00 -> acc=0x02. C is preserved across the LDA.
- Logic ops and flag hold: with C=1, V=1, LDA 0xF0 then AND 0x0F -> acc=0x00, Z=1, C=1, V=1 held. Then NOTA -> acc=0xFF, N=1.
- Handshake and illegal opcode:
  - in_valid held high continuously -> accepts spaced exactly 3 cycles apart, in_ready low in EXEC/RESP.
  - in_op=13 -> err pulse, acc and flags unchanged, no done.

Source files
------------

// File: rtl/acc_unit.sv
// acc_unit: accumulator and C/V/Z/N flag stage downstream of an n-bit ALU.
// Takes one operation at a time over valid/ready. Every opcode walks
// IDLE -> EXEC -> RESP, so throughput is one op per three cycles.
module acc_unit #(
   parameter int n = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   in_op,
   input  logic [n-1:0] in_data,
   output logic [n-1:0] alu_in0,
   output logic [n-1:0] alu_in1,
   output logic [2:0]   alu_ctrl,
   output logic         alu_c_in,
   input  logic [n-1:0] alu_out,
   input  logic         alu_c_out,
   input  logic         alu_v,
   output logic [n-1:0] acc,
   output logic         flag_c,
   output logic         flag_v,
   output logic         flag_z,
   output logic         flag_n,
   output logic         done,
   output logic         err
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_OR   = 4'd2,
                          OP_ORN  = 4'd3,  OP_AND  = 4'd4,  OP_ANDN = 4'd5,
                          OP_NOTA = 4'd6,  OP_NOTB = 4'd7,  OP_ADC  = 4'd8,
                          OP_SBC  = 4'd9,  OP_LDA  = 4'd10, OP_CLR  = 4'd11;

   state_t       state, state_nxt;
   logic [3:0]   op_q;
   logic         accept;
   logic [2:0]   ctrl_dec;
   logic         cin_dec;
   logic [n-1:0] acc_nxt;
   logic         wr_acc, wr_cv, clr, legal;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;
   // Operand 0 is always the live accumulator; the ALU settles during EXEC.
   assign alu_in0  = acc;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state: fixed three-cycle walk once an op is accepted
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Opcode -> ALU control/carry-in, evaluated at accept time.
   // ADC/SBC take the carry in from the current C flag to chain words.
   always_comb begin
      ctrl_dec = 3'b000;
      cin_dec  = 1'b0;
      case (in_op)
         OP_ADD, OP_SUB, OP_OR, OP_ORN,
         OP_AND, OP_ANDN, OP_NOTA, OP_NOTB: begin
            ctrl_dec = in_op[2:0];
            cin_dec  = (in_op == OP_SUB);
         end
         OP_ADC:  begin ctrl_dec = 3'b000; cin_dec = flag_c; end
         OP_SBC:  begin ctrl_dec = 3'b001; cin_dec = flag_c; end
         default: begin ctrl_dec = 3'b000; cin_dec = 1'b0;   end
      endcase
   end

   // Retire-time decode of the held op: what gets written at the EXEC edge
   always_comb begin
      acc_nxt = alu_out;
      wr_acc  = 1'b0;
      wr_cv   = 1'b0;
      clr     = 1'b0;
      legal   = 1'b1;
      case (op_q)
         OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
            wr_acc = 1'b1;
            wr_cv  = 1'b1;
         end
         OP_OR, OP_ORN, OP_AND, OP_ANDN, OP_NOTA, OP_NOTB: wr_acc = 1'b1;
         OP_LDA: begin
            acc_nxt = alu_in1;
            wr_acc  = 1'b1;
         end
         OP_CLR:  clr   = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   // Operand/control capture at accept; result, flags and pulses at EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         alu_in1  <= '0;
         alu_ctrl <= '0;
         alu_c_in <= 1'b0;
         acc      <= '0;
         flag_c   <= 1'b0;
         flag_v   <= 1'b0;
         flag_z   <= 1'b0;
         flag_n   <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (accept) begin
            op_q     <= in_op;
            alu_in1  <= in_data;
            alu_ctrl <= ctrl_dec;
            alu_c_in <= cin_dec;
         end
         if (state == EXEC) begin
            done <= legal;
            err  <= !legal;
            if (clr) begin
               acc    <= '0;
               flag_c <= 1'b0;
               flag_v <= 1'b0;
               flag_z <= 1'b0;
               flag_n <= 1'b0;
            end else if (wr_acc) begin
               acc    <= acc_nxt;
               flag_z <= (acc_nxt == '0);
               flag_n <= acc_nxt[n-1];
               if (wr_cv) begin
                  flag_c <= alu_c_out;
                  flag_v <= alu_v;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_acc_unit.sv
// tb_acc_unit: directed vectors against acc_unit with a behavioural 8-bit ALU
// attached; expected values are hand-computed constants.
module tb_acc_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_op;
   logic [7:0] in_data;
   logic [7:0] alu_in0, alu_in1, alu_out, acc;
   logic [2:0] alu_ctrl;
   logic       alu_c_in, alu_c_out, alu_v;
   logic       flag_c, flag_v, flag_z, flag_n, done, err;

   int n_chk  = 0;
   int n_fail = 0;

   acc_unit #(.n(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
      .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_ctrl(alu_ctrl), .alu_c_in(alu_c_in),
      .alu_out(alu_out), .alu_c_out(alu_c_out), .alu_v(alu_v),
      .acc(acc), .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: add, subtract as a + ~b + cin, then the logic ops
   always_comb begin
      logic [7:0] b;
      logic [8:0] s;
      b = (alu_ctrl == 3'b001) ? ~alu_in1 : alu_in1;
      s = {1'b0, alu_in0} + {1'b0, b} + {8'd0, alu_c_in};
      alu_out   = s[7:0];
      alu_c_out = 1'b0;
      alu_v     = 1'b0;
      case (alu_ctrl)
         3'b000, 3'b001: begin
            alu_c_out = s[8];
            alu_v     = (alu_in0[7] == b[7]) && (s[7] != alu_in0[7]);
         end
         3'b010:  alu_out = alu_in0 | alu_in1;
         3'b011:  alu_out = alu_in0 | ~alu_in1;
         3'b100:  alu_out = alu_in0 & alu_in1;
         3'b101:  alu_out = alu_in0 & ~alu_in1;
         3'b110:  alu_out = ~alu_in0;
         default: alu_out = ~alu_in1;
      endcase
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one op; returns at the negedge inside RESP (result and done visible)
   task automatic run_op(input logic [3:0] op, input logic [7:0] d);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_data = d;
      for (int k = 0; k < 8 && !ok; k++) begin
         if (in_ready) ok = 1'b1;
         @(posedge clk);
      end
      chk("accept_timeout", {15'd0, ok}, 16'd1);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("ready_in_exec", {15'd0, in_ready}, 16'd0);
      @(negedge clk);
   endtask

   // Flags packed as {C,V,Z,N}
   task automatic chk_res(input string tag, input logic [7:0] a, input logic [3:0] f,
                          input logic dn, input logic er);
      chk({tag, "_acc"},   {8'd0, acc}, {8'd0, a});
      chk({tag, "_flags"}, {12'd0, flag_c, flag_v, flag_z, flag_n}, {12'd0, f});
      chk({tag, "_done"},  {15'd0, done}, {15'd0, dn});
      chk({tag, "_err"},   {15'd0, err}, {15'd0, er});
   endtask

   initial begin
      bit seen_done;
      rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_data = '0;
      repeat (2) @(negedge clk);
      chk_res("reset", 8'h00, 4'b0000, 1'b0, 1'b0);
      chk("reset_ready", {15'd0, in_ready}, 16'd1);
      rst_n = 1'b1;

      // Signed overflow into the sign bit
      run_op(4'd10, 8'h7F);
      chk_res("lda7f", 8'h7F, 4'b0000, 1'b1, 1'b0);
      run_op(4'd0, 8'h01);
      chk_res("add_ovf", 8'h80, 4'b0100 | 4'b0001, 1'b1, 1'b0);
      @(negedge clk);
      chk("done_one_cycle", {15'd0, done}, 16'd0);
      chk("ready_back", {15'd0, in_ready}, 16'd1);

      // Subtract to zero, then borrow
      run_op(4'd10, 8'h05);
      run_op(4'd1, 8'h05);
      chk_res("sub_zero", 8'h00, 4'b1010, 1'b1, 1'b0);
      run_op(4'd1, 8'h01);
      chk_res("sub_borrow", 8'hFF, 4'b0001, 1'b1, 1'b0);

      // 16-bit 0x01FF + 0x0001, low word already in acc as 0xFF
      run_op(4'd0, 8'h01);
      chk_res("mw_lo", 8'h00, 4'b1010, 1'b1, 1'b0);
      run_op(4'd10, 8'h01);
      chk_res("mw_lda_holdc", 8'h01, 4'b1000, 1'b1, 1'b0);
      run_op(4'd8, 8'h00);
      chk_res("mw_adc", 8'h02, 4'b0000, 1'b1, 1'b0);

      // Set C=1,V=1 (0x80+0x80), then logic ops must hold them
      run_op(4'd10, 8'h80);
      run_op(4'd0, 8'h80);
      chk_res("set_cv", 8'h00, 4'b1110, 1'b1, 1'b0);
      run_op(4'd10, 8'hF0);
      run_op(4'd4, 8'h0F);
      chk_res("and_hold", 8'h00, 4'b1110, 1'b1, 1'b0);
      run_op(4'd6, 8'h00);
      chk_res("nota", 8'hFF, 4'b1101, 1'b1, 1'b0);

      // Illegal opcode: nothing changes, err instead of done
      run_op(4'd13, 8'h12);
      chk_res("illegal", 8'hFF, 4'b1101, 1'b0, 1'b1);
      @(negedge clk);
      chk("err_one_cycle", {15'd0, err}, 16'd0);

      // CLR zeroes acc and every flag
      run_op(4'd11, 8'h00);
      chk_res("clr", 8'h00, 4'b0000, 1'b1, 1'b0);
      @(negedge clk);

      // Continuous in_valid: ready (and accepts) every third cycle
      in_valid = 1'b1; in_op = 4'd10; in_data = 8'h81;
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("hold_ready_%0d", i), {15'd0, in_ready}, {15'd0, (i % 3) == 0});
         if (i % 3 == 2) chk($sformatf("hold_done_%0d", i), {15'd0, done}, 16'd1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk_res("hold_lda", 8'h81, 4'b0001, 1'b0, 1'b0);

      // Reset in the middle of EXEC abandons the op
      @(negedge clk);
      in_valid = 1'b1; in_op = 4'd0; in_data = 8'h7F;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_res("rst_exec", 8'h00, 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (done || err) seen_done = 1'b1;
         @(negedge clk);
      end
      chk("rst_no_done", {15'd0, seen_done}, 16'd0);
      chk("rst_ready", {15'd0, in_ready}, 16'd1);
      chk("rst_acc_stays", {8'd0, acc}, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
